// File: rtl/tenbaset_pkg.sv
// Shared types and timing constants for the 10BASE-T transmit scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tenbaset_pkg;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_SEND,
        ST_GAP
    } tx_sched_state_t;

    // 96 bit times at 10 Mb/s, counted in 20 MHz cycles
    localparam int TENBASET_IFG_CYCLES       = 192;
    // Longest frame incl. preamble/SFD/CRC: 1526 bytes x 16 cycles per byte
    localparam int TENBASET_MAX_FRAME_CYCLES = 24416;

endpackage

// File: rtl/tenbaset_tx_scheduler_rr_arbiter.sv
// Round-robin pick: first set req bit scanning upward from ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt_oh,
    output logic [$clog2(NREQ)-1:0] gnt_idx,
    output logic                    gnt_vld
);

    localparam int IDX_W = $clog2(NREQ);

    // Walk the requesters starting at ptr; the first hit wins
    always_comb begin
        logic [IDX_W-1:0] idx;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(ptr) + i >= NREQ) begin
                idx = IDX_W'(int'(ptr) + i - NREQ);
            end else begin
                idx = IDX_W'(int'(ptr) + i);
            end
            if (!gnt_vld && req[idx]) begin
                gnt_vld     = 1'b1;
                gnt_idx     = idx;
                gnt_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tenbaset_tx_scheduler.sv
// Shares one 10BASE-T transmitter among NREQ sources: round-robin grant, start pulse, IFG, watchdog.
// Latency: req seen in IDLE -> gnt/tx_start next cycle; tx_done -> done next cycle.
// Backpressure: sources hold req until done/err_timeout; no arbitration outside IDLE.
module tenbaset_tx_scheduler
    import tenbaset_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int IFG_CYCLES     = TENBASET_IFG_CYCLES,
    parameter int TIMEOUT_CYCLES = 32768,
    parameter int CNT_W          = 16
) (
    input  logic                    clk20,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx,
    output logic [NREQ-1:0]         done,
    output logic                    tx_start,
    input  logic                    tx_busy,
    input  logic                    tx_done,
    output logic                    err_timeout,
    output logic                    idle
);

    localparam int IDX_W = $clog2(NREQ);

    tx_sched_state_t  state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             tx_start_q, tx_start_d;
    logic             err_timeout_q, err_timeout_d;
    logic             idle_q, idle_d;

    logic [NREQ-1:0]  arb_oh;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_vld;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // Next-state and next-output logic for the scheduler FSM
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        gnt_d         = gnt_q;
        gnt_idx_d     = gnt_idx_q;
        done_d        = '0;
        tx_start_d    = 1'b0;
        err_timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    gnt_d      = arb_oh;
                    gnt_idx_d  = arb_idx;
                    ptr_d      = (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                    tx_start_d = 1'b1;
                    // Watchdog counts from the tx_start cycle itself so that
                    // expiry lands exactly TIMEOUT_CYCLES after the start pulse.
                    cnt_d      = CNT_W'(TIMEOUT_CYCLES - 1);
                    state_d    = ST_START;
                end
            end

            ST_START: begin
                // tx_done cannot be meaningful here: the transmitter only now sees start
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY, ST_SEND: begin
                if (tx_done) begin
                    // Completion wins over a watchdog expiry in the same cycle
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    cnt_d   = CNT_W'(IFG_CYCLES - 1);
                    state_d = ST_GAP;
                end else if (cnt_q == '0) begin
                    err_timeout_d = 1'b1;
                    gnt_d         = '0;
                    cnt_d         = CNT_W'(IFG_CYCLES - 1);
                    state_d       = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (state_q == ST_WAIT_BUSY && tx_busy) begin
                        state_d = ST_SEND;
                    end
                end
            end

            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        idle_d = (state_d == ST_IDLE);
    end

    // State, pointer, counter and all outputs are registered here
    always_ff @(posedge clk20) begin
        if (rst) begin
            // idle tracks the IDLE state, so it comes up high while everything else is cleared
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            gnt_q         <= '0;
            gnt_idx_q     <= '0;
            done_q        <= '0;
            tx_start_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            idle_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            gnt_q         <= gnt_d;
            gnt_idx_q     <= gnt_idx_d;
            done_q        <= done_d;
            tx_start_q    <= tx_start_d;
            err_timeout_q <= err_timeout_d;
            idle_q        <= idle_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_idx     = gnt_idx_q;
    assign done        = done_q;
    assign tx_start    = tx_start_q;
    assign err_timeout = err_timeout_q;
    assign idle        = idle_q;

endmodule

// File: tb/tb_tenbaset_tx_scheduler.sv
module tb_tenbaset_tx_scheduler;

    localparam int NREQ = 4;
    localparam int IFG  = 192;
    localparam int TO   = 32768;

    localparam int K_NORMAL   = 0;
    localparam int K_TIMEOUT  = 1;
    localparam int K_COINCIDE = 2;

    logic            clk20;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [1:0]      gnt_idx;
    logic [NREQ-1:0] done;
    logic            tx_start;
    logic            tx_busy;
    logic            tx_done;
    logic            err_timeout;
    logic            idle;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int mptr     = 0;     // reference model's round-robin pointer
    int start_cyc;        // absolute cycle of the last observed tx_start
    int first_idx;        // gnt_idx seen on the last tx_start cycle

    tenbaset_tx_scheduler #(
        .NREQ           (NREQ),
        .IFG_CYCLES     (IFG),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (16)
    ) dut (
        .clk20       (clk20),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .done        (done),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .err_timeout (err_timeout),
        .idle        (idle)
    );

    initial clk20 = 1'b0;
    always #5 clk20 = ~clk20;
    always @(posedge clk20) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Round robin in plain terms: first requester at or after the pointer, wrapping.
    function automatic int model_pick(input logic [NREQ-1:0] pat, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (p + k) % NREQ;
            if (pat[c]) return c;
        end
        return 0;
    endfunction

    task automatic step();
        @(posedge clk20);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; tx_busy = 1'b0; tx_done = 1'b0;
        repeat (3) step();
        chk("rst_gnt", gnt, 0);
        chk("rst_idx", gnt_idx, 0);
        chk("rst_done", done, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_idle", idle, 1);
        rst  = 1'b0;
        mptr = 0;
    endtask

    // One complete grant: request in IDLE, transmitter behaviour per kind, then the
    // whole frame + gap is observed cycle by cycle against the timeline the model predicts.
    // t = 0 is the tx_start cycle; dec_t is the cycle completion/expiry is decided.
    task automatic run_frame(input logic [NREQ-1:0] pat, input int kind, input int bd,
                             input int end_t, input bit drop);
        int win, dec_t, lat, n_start, bad_gnt, bad_idx, bad_done, bad_err, bad_idle;
        logic [NREQ-1:0] oh, exp_gnt, exp_done;
        win   = model_pick(pat, mptr);
        mptr  = (win + 1) % NREQ;
        oh    = NREQ'(1) << win;
        dec_t = (kind == K_NORMAL) ? end_t : TO - 1;
        req   = pat;
        lat   = 0;
        do begin
            step();
            lat++;
        end while (!tx_start && lat < 4);
        chk("start_latency", lat, 1);
        chk("gnt_onehot", gnt, oh);
        chk("gnt_idx", gnt_idx, win);
        start_cyc = cyc;
        first_idx = int'(gnt_idx);
        n_start = 0; bad_gnt = 0; bad_idx = 0; bad_done = 0; bad_err = 0; bad_idle = 0;
        for (int t = 0; t <= dec_t + IFG + 1; t++) begin
            if (t > 0) step();
            case (kind)
                K_NORMAL:   begin tx_busy = (t >= bd && t < end_t); tx_done = (t == end_t); end
                K_COINCIDE: begin tx_busy = (t >= 2 && t < dec_t);  tx_done = (t == dec_t); end
                default:    begin tx_busy = 1'b0;                   tx_done = 1'b0;         end
            endcase
            if (drop && t == 3) req = '0;
            exp_gnt  = (t <= dec_t) ? oh : '0;
            exp_done = (t == dec_t + 1 && kind != K_TIMEOUT) ? oh : '0;
            if (tx_start) n_start++;
            if (gnt !== exp_gnt) bad_gnt++;
            if (gnt_idx !== 2'(win)) bad_idx++;
            if (done !== exp_done) bad_done++;
            if (err_timeout !== (t == dec_t + 1 && kind == K_TIMEOUT)) bad_err++;
            if (idle !== (t == dec_t + IFG + 1)) bad_idle++;
        end
        tx_busy = 1'b0;
        tx_done = 1'b0;
        chk("start_pulses", n_start, 1);
        chk("gnt_cycles_bad", bad_gnt, 0);
        chk("idx_cycles_bad", bad_idx, 0);
        chk("done_cycles_bad", bad_done, 0);
        chk("err_cycles_bad", bad_err, 0);
        chk("idle_cycles_bad", bad_idle, 0);
    endtask

    initial begin
        int prev_start, prev_end, e, n_bad;
        rst = 1'b1; req = '0; tx_busy = 1'b0; tx_done = 1'b0;

        // Reset values, then a single 1000-cycle frame from source 0
        do_reset();
        run_frame(4'b0001, K_NORMAL, 2, 1002, 1'b0);

        // All sources continuously: order 0,1,2,3,0 and start spacing = frame + IFG + 2
        do_reset();
        prev_start = 0;
        prev_end   = 0;
        for (int i = 0; i < 5; i++) begin
            e = $urandom_range(20, 200);
            run_frame(4'b1111, K_NORMAL, $urandom_range(1, 3), e, 1'b0);
            chk("rr_order", first_idx, i % NREQ);
            if (i > 0) chk("start_spacing", start_cyc - prev_start, prev_end + IFG + 2);
            prev_start = start_cyc;
            prev_end   = e;
        end

        // Sources 1 and 3 only: 1, then 3, then 1
        run_frame(4'b1010, K_NORMAL, 2, 40, 1'b0);
        chk("pair_first", first_idx, 1);
        run_frame(4'b1010, K_NORMAL, 2, 40, 1'b0);
        chk("pair_second", first_idx, 3);
        run_frame(4'b1010, K_NORMAL, 2, 40, 1'b0);
        chk("pair_third", first_idx, 1);

        // Transmitter never responds: watchdog fires TO cycles after tx_start
        run_frame(4'b0001, K_TIMEOUT, 0, 0, 1'b0);

        // req dropped mid-frame and tx_done on the expiry cycle: normal completion
        run_frame(4'b0001, K_COINCIDE, 2, 0, 1'b1);

        // Reset while in SEND
        req = 4'b0001;
        step();
        chk("pre_rst_start", tx_start, 1);
        for (int t = 1; t <= 12; t++) begin
            tx_busy = (t >= 2);
            if (t < 12) step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0; tx_busy = 1'b0; req = '0;
        chk("midrst_gnt", gnt, 0);
        chk("midrst_idx", gnt_idx, 0);
        chk("midrst_done", done, 0);
        chk("midrst_start", tx_start, 0);
        chk("midrst_err", err_timeout, 0);
        chk("midrst_idle", idle, 1);
        n_bad = 0;
        for (int t = 0; t < 300; t++) begin
            step();
            if (done !== '0 || err_timeout !== 1'b0 || tx_start !== 1'b0 || idle !== 1'b1) n_bad++;
        end
        chk("post_rst_quiet", n_bad, 0);
        mptr = 0;
        run_frame(4'b0011, K_NORMAL, 2, 30, 1'b0);
        chk("post_rst_ptr0", first_idx, 0);
        run_frame(4'b0100, K_NORMAL, 2, 30, 1'b0);
        chk("post_rst_src2", first_idx, 2);

        // Randomised traffic against the model
        for (int i = 0; i < 16; i++) begin
            logic [NREQ-1:0] pat;
            int end_t;
            pat   = NREQ'($urandom_range(1, 15));
            end_t = $urandom_range(2, 150);
            run_frame(pat, K_NORMAL, $urandom_range(1, end_t + 1), end_t, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tenbaset_tx_scheduler.md
# tenbaset_tx_scheduler

Round-robin scheduler that shares the single 10BASE-T frame transmitter among NREQ packet sources. It grants one requester at a time, pulses the transmitter's start input, tracks the frame to completion, enforces the 802.3 inter-frame gap, and aborts stuck frames with a watchdog. It sits between the packet-source blocks (UDP payload generators) and the transmitter, and its `gnt_idx` steers the payload-byte mux feeding the transmitter.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IFG_CYCLES`, 192: idle gap after each frame, in clk20 cycles (96 bit times at 10 Mb/s).
- `TIMEOUT_CYCLES`, 32768: watchdog limit from `tx_start` to `tx_done`. Must exceed the longest frame (1526 bytes × 16 = 24416 cycles).
- `CNT_W`, 16: width of the shared gap/watchdog counter. Must satisfy 2^CNT_W > max(IFG_CYCLES, TIMEOUT_CYCLES).

Ports:
- `clk20`, in, 1: 20 MHz clock; the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, NREQ: per-source request. The source holds it high until it sees its `done` or `err_timeout`.
- `gnt`, out, NREQ: one-hot grant, registered.
- `gnt_idx`, out, $clog2(NREQ): index of the granted source; payload mux select.
- `done`, out, NREQ: one-cycle pulse on the granted bit when its frame completes.
- `tx_start`, out, 1: one-cycle start pulse to the transmitter.
- `tx_busy`, in, 1: transmitter is serialising a frame.
- `tx_done`, in, 1: one-cycle pulse at end of frame (after CRC).
- `err_timeout`, out, 1: one-cycle pulse when the watchdog expires.
- `idle`, out, 1: high in IDLE state only.

## Operation
- States: IDLE, START, WAIT_BUSY, SEND, GAP.
- IDLE, with any `req` bit set:
  - Pick the first set bit scanning upward from `ptr`, wrapping modulo NREQ.
  - Register `gnt`/`gnt_idx`, set `ptr` ← winner+1 (mod NREQ), go to START.
- START: `tx_start`=1 for this cycle only; load counter with TIMEOUT_CYCLES-1; go to WAIT_BUSY.
- WAIT_BUSY: `tx_busy`=1 → SEND.
- SEND: `tx_done`=1 → GAP.
- Completion:
  - A `tx_done` pulse seen in either WAIT_BUSY or SEND completes the frame.
  - On completion: `done[gnt_idx]` pulses on the GAP-entry cycle and `gnt` clears to 0.
- Watchdog, in WAIT_BUSY and SEND:
  - The counter decrements each cycle.
  - At 0 with no `tx_done` that cycle: `err_timeout` pulses, `gnt` clears, no `done`, go to GAP.
  - `tx_done` and expiry in the same cycle count as a normal completion.
- GAP: load counter with IFG_CYCLES-1 on entry; decrement; at 0 go to IDLE. Requests are not arbitrated during GAP.
- Other rules:
  - `req` deasserting while granted is ignored; the frame runs to completion.
  - `gnt_idx` holds its last value while `gnt`=0.
  - Counter width CNT_W, unsigned, no wrap: it is always reloaded before use.
- Reset:
  - All outputs 0, state IDLE, `ptr`=0, counter 0.
  - `idle`=1 from the first cycle after reset.
  - Reset mid-frame abandons the frame; no `done` or `err_timeout` pulse.

## Timing
- All outputs are registered.
- `req` sampled in IDLE at cycle N:
  - `gnt` and `tx_start` high at N+1.
  - WAIT_BUSY at N+2.
- `tx_done` at cycle T:
  - `done` at T+1 (the first GAP cycle).
  - GAP occupies T+1..T+IFG_CYCLES; IDLE at T+IFG_CYCLES+1.
  - Earliest next `tx_start` is T+IFG_CYCLES+2.
- Watchdog: `err_timeout` at `tx_start` cycle + TIMEOUT_CYCLES, when no `tx_done` has arrived.
- Throughput: a continuously requesting source gets at most one frame per NREQ frames while others also request.

## Structure
- Package `tenbaset_pkg`:
  - State enum `tx_sched_state_t`.
  - Constants `TENBASET_IFG_CYCLES`=192 and `TENBASET_MAX_FRAME_CYCLES`=24416.
- Sub-module `rr_arbiter`:
  - Parameter NREQ.
  - Combinational pick from `req` and `ptr`, giving one-hot result and index.
  - The scheduler owns `ptr` and the FSM.

## Test plan
- Single source: `req`=4'b0001, transmitter model asserts `tx_busy` 2 cycles after `tx_start` and `tx_done` 1000 cycles later → one `tx_start`, `done[0]` 1 cycle after `tx_done`, `idle` 193 cycles after `tx_done`.
- All four sources requesting continuously from reset → grant order 0,1,2,3,0; every `tx_start` spacing ≥ frame length + 194 cycles.
- Sources 1 and 3 requesting, `ptr`=2 after granting 1 → next grant 3, then 1.
- `tx_busy` never asserts → `err_timeout` exactly 32768 cycles after `tx_start`, no `done`, `gnt`=0, IDLE after 192 more cycles.
- Reset asserted during SEND → next cycle all outputs 0 and `idle`=1; after release `req`=4'b0100 is granted with `ptr` starting at 0.
- `req[0]` dropped mid-frame, and `tx_done` coinciding with watchdog expiry → frame completes, `done[0]` pulses, no `err_timeout`.
